hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline interlock and flush sequencer for the 5-stage MIPS core. It watches the decode stage's source register addresses, the load in EX, redirects resolved in EX and data-memory back-pressure. From these it produces stall and flush strobes for PC, IF/ID, ID/EX and EX/MEM. A small FSM stretches load-use bubbles to a configurable length, and an optional counter records stall cycles.

Parameters:
LU_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock, all state updated on rising edge
nrst  in  1  synchronous active-low reset, sampled on rising edge of clk
i_ID_RSAddr  in  5  rs field of instruction in ID
i_ID_RTAddr  in  5  rt field of instruction in ID
i_ID_UsesRT  in  1  ID instruction reads rt (R-type, store, branch)
i_EX_MemRead  in  1  instruction in EX is a load
i_EX_RTAddr  in  5  destination (rt) of instruction in EX
i_EX_Taken  in  1  branch taken / jump / jr resolved in EX this cycle
i_MEM_Busy  in  1  data memory not ready; MEM must hold
o_PC_Stall  out  1  hold PC
o_IFID_Stall  out  1  hold IF/ID register
o_IFID_Flush  out  1  load NOP into IF/ID
o_IDEX_Flush  out  1  load bubble (all ctrl 0) into ID/EX
o_EXMEM_Stall  out  1  hold ID/EX and EX/MEM registers
o_State  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT
o_StallCount  out  CNT_W  cycles with o_PC_Stall=1

Behaviour:
- Output timing: all strobes are combinational from current state and inputs, so they are valid in the same cycle. State, bubble counter and perf counter are registered.
- Reset, nrst=0 at a clock edge: state<=RUN, bubble counter<=0, o_StallCount<=0.
- While nrst=0: o_IFID_Flush=1, o_IDEX_Flush=1, all stall outputs 0, o_State=0.
- LU hazard = i_EX_MemRead && i_EX_RTAddr!=0 && (i_EX_RTAddr==i_ID_RSAddr || (i_ID_UsesRT && i_EX_RTAddr==i_ID_RTAddr)).
- Priority each cycle: i_MEM_Busy > i_EX_Taken > LU hazard / LU_STALL.
- MEM_Busy, in any state: PC_Stall=IFID_Stall=EXMEM_Stall=1 and both flushes 0.
  - Next state is MEM_WAIT.
  - The bubble counter is frozen and the pre-busy state is saved. On busy deassertion the FSM returns to the saved state.
  - EX is held, so i_EX_Taken stays asserted and is serviced after busy deasserts.
- RUN:
  - i_EX_Taken=1: IFID_Flush=1, IDEX_Flush=1, no stalls. Stay RUN.
  - LU hazard: PC_Stall=1, IFID_Stall=1, IDEX_Flush=1.
  - If LU_BUBBLES>1, go to LU_STALL with counter=LU_BUBBLES-1. Otherwise stay RUN.
  - Otherwise: all outputs 0.
- LU_STALL: PC_Stall=1, IFID_Stall=1, IDEX_Flush=1.
  - The hazard condition is not re-evaluated here.
  - Counter decrements each cycle. When counter==1, go to RUN next cycle.
  - i_EX_Taken=1 here (defensive only, since EX holds a bubble): flush wins, counter is cleared and next state is RUN.
- o_StallCount increments by 1 on every cycle with o_PC_Stall=1 and nrst=1. It saturates at all-ones with no wrap.
- Illegal state encoding 3: treated as RUN and corrected next cycle.

Optional Feature:
HAZARD_PERF_EN
- Defined: o_StallCount is implemented as above.
- Undefined: counter logic is removed and o_StallCount is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- lw $2 in EX (MemRead=1, EX_RTAddr=2), ID RSAddr=2, LU_BUBBLES=1 -> one cycle PC_Stall=IFID_Stall=IDEX_Flush=1, next cycle all 0, StallCount=1.
- Same stimulus with EX_RTAddr=0, or RTAddr match with UsesRT=0 -> no stall, all outputs 0.
- LU_BUBBLES=3, hazard -> stall strobes for exactly 3 cycles, o_State 0,1,1,0, StallCount=3.
- i_EX_Taken=1 together with an LU hazard -> IFID_Flush=IDEX_Flush=1, PC_Stall=0, state stays RUN.
- MEM_Busy for 4 cycles during LU_STALL (counter=2) -> all stalls held 4 cycles with State=2, then resume LU_STALL with 2 remaining bubbles. With HAZARD_PERF_EN, StallCount +6.
- nrst=0 asserted mid-LU_STALL -> flush outputs 1, next edge State=0, StallCount=0. Counter preset to all-ones -1 with 3 stall cycles -> saturates at all-ones.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline interlock and flush sequencer for the 5-stage MIPS
//               core. Detects load-use hazards and stretches them to
//               LU_BUBBLES bubbles. Redirects taken in EX flush IF/ID and
//               ID/EX. Data-memory back-pressure freezes the front of the
//               pipe. The optional stall-cycle performance counter is built
//               only when HAZARD_PERF_EN is defined. Otherwise o_StallCount
//               is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [4:0]       i_ID_RSAddr,
    input  logic [4:0]       i_ID_RTAddr,
    input  logic             i_ID_UsesRT,
    input  logic             i_EX_MemRead,
    input  logic [4:0]       i_EX_RTAddr,
    input  logic             i_EX_Taken,
    input  logic             i_MEM_Busy,
    output logic             o_PC_Stall,
    output logic             o_IFID_Stall,
    output logic             o_IFID_Flush,
    output logic             o_IDEX_Flush,
    output logic             o_EXMEM_Stall,
    output logic [1:0]       o_State,
    output logic [CNT_W-1:0] o_StallCount
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_LU_STALL = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;
    localparam logic [2:0] c_BUB_INIT    = 3'(LU_BUBBLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_saved;     // state to resume once memory stops stalling
    logic [2:0] r_bub_cnt;   // load-use bubbles still to insert

    logic [1:0] w_eff_state;
    logic       w_lu_hazard;
    logic [1:0] w_nxt_state;
    logic [1:0] w_nxt_saved;
    logic [2:0] w_nxt_cnt;
    logic       w_pc_stall;
    logic       w_ifid_stall;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_exmem_stall;

    assign w_lu_hazard = i_EX_MemRead && (i_EX_RTAddr != 5'd0) &&
                         ((i_EX_RTAddr == i_ID_RSAddr) ||
                          (i_ID_UsesRT && (i_EX_RTAddr == i_ID_RTAddr)));

    // Behaviour this cycle follows the saved state once memory releases us,
    // and the unused encoding behaves as RUN so it self-corrects next edge.
    always_comb begin
        w_eff_state = r_state;
        if (r_state == c_ST_MEM_WAIT) begin
            w_eff_state = r_saved;
        end else if (r_state != c_ST_LU_STALL) begin
            w_eff_state = c_ST_RUN;
        end
    end

    // Strobe generation and next-state selection, busy > taken > load-use.
    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_nxt_state   = c_ST_RUN;
        w_nxt_saved   = r_saved;
        w_nxt_cnt     = r_bub_cnt;
        if (i_MEM_Busy) begin
            // Freeze everything upstream of MEM; bubble count is untouched.
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_nxt_state   = c_ST_MEM_WAIT;
            w_nxt_saved   = w_eff_state;
        end else if (i_EX_Taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_nxt_cnt    = 3'd0;
        end else if (w_eff_state == c_ST_LU_STALL) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
            if (r_bub_cnt <= 3'd1) begin
                w_nxt_cnt = 3'd0;
            end else begin
                w_nxt_state = c_ST_LU_STALL;
                w_nxt_cnt   = r_bub_cnt - 3'd1;
            end
        end else if (w_lu_hazard) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
                w_nxt_state = c_ST_LU_STALL;
                w_nxt_cnt   = c_BUB_INIT;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= c_ST_RUN;
            r_saved   <= c_ST_RUN;
            r_bub_cnt <= 3'd0;
        end else begin
            r_state   <= w_nxt_state;
            r_saved   <= w_nxt_saved;
            r_bub_cnt <= w_nxt_cnt;
        end
    end

    // While reset is held the pipe is flushed and nothing stalls.
    assign o_PC_Stall    = nrst & w_pc_stall;
    assign o_IFID_Stall  = nrst & w_ifid_stall;
    assign o_EXMEM_Stall = nrst & w_exmem_stall;
    assign o_IFID_Flush  = ~nrst | w_ifid_flush;
    assign o_IDEX_Flush  = ~nrst | w_idex_flush;
    assign o_State       = nrst ? r_state : c_ST_RUN;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_stall_cnt <= '0;
        end else if (o_PC_Stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_StallCount = r_stall_cnt;
`else
    assign o_StallCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl. Instance u_a
//               uses one bubble with a 32-bit counter. Instance u_b uses
//               three bubbles with a 4-bit counter, so that counter
//               saturation can be reached quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       nrst;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       taken;
    logic       busy;

    logic        a_pc, a_ifs, a_iff, a_idf, a_exs;
    logic [1:0]  a_st;
    logic [31:0] a_cnt;
    logic        b_pc, b_ifs, b_iff, b_idf, b_exs;
    logic [1:0]  b_st;
    logic [3:0]  b_cnt;
    logic [4:0]  a_out;
    logic [4:0]  b_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Flush, EXMEM_Stall}
    assign a_out = {a_pc, a_ifs, a_iff, a_idf, a_exs};
    assign b_out = {b_pc, b_ifs, b_iff, b_idf, b_exs};

    hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u_a (
        .clk(clk), .nrst(nrst),
        .i_ID_RSAddr(rs_addr), .i_ID_RTAddr(rt_addr), .i_ID_UsesRT(uses_rt),
        .i_EX_MemRead(mem_read), .i_EX_RTAddr(ex_rt), .i_EX_Taken(taken),
        .i_MEM_Busy(busy),
        .o_PC_Stall(a_pc), .o_IFID_Stall(a_ifs), .o_IFID_Flush(a_iff),
        .o_IDEX_Flush(a_idf), .o_EXMEM_Stall(a_exs), .o_State(a_st),
        .o_StallCount(a_cnt)
    );

    hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u_b (
        .clk(clk), .nrst(nrst),
        .i_ID_RSAddr(rs_addr), .i_ID_RTAddr(rt_addr), .i_ID_UsesRT(uses_rt),
        .i_EX_MemRead(mem_read), .i_EX_RTAddr(ex_rt), .i_EX_Taken(taken),
        .i_MEM_Busy(busy),
        .o_PC_Stall(b_pc), .o_IFID_Stall(b_ifs), .o_IFID_Flush(b_iff),
        .o_IDEX_Flush(b_idf), .o_EXMEM_Stall(b_exs), .o_State(b_st),
        .o_StallCount(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stall count: the counter only exists in the perf build.
    function automatic int unsigned perf(input int unsigned n);
`ifdef HAZARD_PERF_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, then let the combinational strobes settle.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                         input logic mr, input logic [4:0] ert, input logic tk,
                         input logic bs);
        rs_addr  = rs;
        rt_addr  = rt;
        uses_rt  = u;
        mem_read = mr;
        ex_rt    = ert;
        taken    = tk;
        busy     = bs;
        #2;
    endtask

    task automatic reset_both();
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        drive(2, 0, 0, 1, 2, 1, 1);
        n_checks++;
        if (a_out !== 5'b00110 || a_st !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%b st=%0d expected out=00110 st=0", a_out, a_st);
        end
        step();
        n_checks++;
        if (b_st !== 2'd0 || b_cnt !== 4'd0 || a_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d cnt=%0d/%0d expected 0 0/0", b_st, a_cnt, b_cnt);
        end
        nrst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (a_out !== 5'b00000 || b_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_release: got %b/%b expected 00000/00000", a_out, b_out);
        end
        step();
    endtask

    task automatic test_lu1();
        reset_both();
        drive(2, 0, 0, 1, 2, 0, 0);
        n_checks++;
        if (a_out !== 5'b11010 || a_st !== 2'd0) begin
            n_fail++;
            $display("FAIL lu1_rs_stall: got out=%b st=%0d expected out=11010 st=0", a_out, a_st);
        end
        step();
        drive(2, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (a_out !== 5'b00000 || a_st !== 2'd0 || a_cnt !== 32'(perf(1))) begin
            n_fail++;
            $display("FAIL lu1_release: got out=%b st=%0d cnt=%0d expected out=00000 st=0 cnt=%0d",
                     a_out, a_st, a_cnt, perf(1));
        end
        step();
        drive(5, 7, 1, 1, 7, 0, 0);
        n_checks++;
        if (a_out !== 5'b11010) begin
            n_fail++;
            $display("FAIL lu1_rt_stall: got %b expected 11010", a_out);
        end
        step();
    endtask

    task automatic test_no_hazard();
        reset_both();
        drive(0, 0, 1, 1, 0, 0, 0);
        n_checks++;
        if (a_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL nohaz_r0: got %b expected 00000", a_out);
        end
        step();
        drive(3, 2, 0, 1, 2, 0, 0);
        n_checks++;
        if (a_out !== 5'b00000 || b_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL nohaz_rt_unused: got %b/%b expected 00000/00000", a_out, b_out);
        end
        step();
        drive(2, 0, 0, 0, 2, 0, 0);
        n_checks++;
        if (a_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL nohaz_no_load: got %b expected 00000", a_out);
        end
        step();
        n_checks++;
        if (b_st !== 2'd0 || a_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL nohaz_idle: got st=%0d cnt=%0d expected st=0 cnt=0", b_st, a_cnt);
        end
    endtask

    task automatic test_lu3();
        logic [4:0] exp_o [0:3];
        logic [1:0] exp_s [0:3];
        exp_o[0] = 5'b11010; exp_s[0] = 2'd0;
        exp_o[1] = 5'b11010; exp_s[1] = 2'd1;
        exp_o[2] = 5'b11010; exp_s[2] = 2'd1;
        exp_o[3] = 5'b00000; exp_s[3] = 2'd0;
        reset_both();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(2, 0, 0, 1, 2, 0, 0);
            else        drive(2, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (b_out !== exp_o[i] || b_st !== exp_s[i]) begin
                n_fail++;
                $display("FAIL lu3_cycle%0d: got out=%b st=%0d expected out=%b st=%0d",
                         i, b_out, b_st, exp_o[i], exp_s[i]);
            end
            step();
        end
        n_checks++;
        if (b_cnt !== 4'(perf(3))) begin
            n_fail++;
            $display("FAIL lu3_count: got %0d expected %0d", b_cnt, perf(3));
        end
    endtask

    task automatic test_taken();
        reset_both();
        drive(2, 0, 0, 1, 2, 1, 0);
        n_checks++;
        if (a_out !== 5'b00110 || b_out !== 5'b00110) begin
            n_fail++;
            $display("FAIL taken_vs_lu: got %b/%b expected 00110/00110", a_out, b_out);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (b_st !== 2'd0 || b_out !== 5'b00000 || b_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL taken_stay_run: got st=%0d out=%b cnt=%0d expected 0 00000 0", b_st, b_out, b_cnt);
        end
        step();
        drive(2, 0, 0, 1, 2, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (b_out !== 5'b00110 || b_st !== 2'd1) begin
            n_fail++;
            $display("FAIL taken_in_lu: got out=%b st=%0d expected out=00110 st=1", b_out, b_st);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (b_out !== 5'b00000 || b_st !== 2'd0 || b_cnt !== 4'(perf(1))) begin
            n_fail++;
            $display("FAIL taken_lu_exit: got out=%b st=%0d cnt=%0d expected 00000 0 %0d",
                     b_out, b_st, b_cnt, perf(1));
        end
        step();
    endtask

    task automatic test_mem_wait();
        logic [4:0] exp_o [0:7];
        logic [1:0] exp_s [0:7];
        exp_o[0] = 5'b11010; exp_s[0] = 2'd0;
        exp_o[1] = 5'b11001; exp_s[1] = 2'd1;
        exp_o[2] = 5'b11001; exp_s[2] = 2'd2;
        exp_o[3] = 5'b11001; exp_s[3] = 2'd2;
        exp_o[4] = 5'b11001; exp_s[4] = 2'd2;
        exp_o[5] = 5'b11010; exp_s[5] = 2'd2;
        exp_o[6] = 5'b11010; exp_s[6] = 2'd1;
        exp_o[7] = 5'b00000; exp_s[7] = 2'd0;
        reset_both();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)                drive(2, 0, 0, 1, 2, 0, 0);
            else if (i >= 1 && i <= 4) drive(0, 0, 0, 0, 0, 0, 1);
            else                       drive(0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (b_out !== exp_o[i] || b_st !== exp_s[i]) begin
                n_fail++;
                $display("FAIL memwait_cycle%0d: got out=%b st=%0d expected out=%b st=%0d",
                         i, b_out, b_st, exp_o[i], exp_s[i]);
            end
            step();
        end
        n_checks++;
        if (b_cnt !== 4'(perf(7))) begin
            n_fail++;
            $display("FAIL memwait_count: got %0d expected %0d", b_cnt, perf(7));
        end
        // A taken redirect held under busy is serviced as soon as busy drops.
        reset_both();
        drive(0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (a_out !== 5'b11001) begin
            n_fail++;
            $display("FAIL busy_over_taken: got %b expected 11001", a_out);
        end
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (a_out !== 5'b00110 || a_st !== 2'd2) begin
            n_fail++;
            $display("FAIL taken_after_busy: got out=%b st=%0d expected out=00110 st=2", a_out, a_st);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (a_st !== 2'd0 || a_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL busy_exit_run: got st=%0d out=%b expected 0 00000", a_st, a_out);
        end
        step();
    endtask

    task automatic test_reset_mid();
        reset_both();
        drive(2, 0, 0, 1, 2, 0, 0);
        step();
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (b_out !== 5'b00110 || b_st !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got out=%b st=%0d expected out=00110 st=0", b_out, b_st);
        end
        step();
        nrst = 1'b1;
        #2;
        n_checks++;
        if (b_st !== 2'd0 || b_cnt !== 4'd0 || b_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstmid_state: got st=%0d cnt=%0d out=%b expected 0 0 00000", b_st, b_cnt, b_out);
        end
        step();
    endtask

    task automatic test_saturate();
        reset_both();
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (b_cnt !== 4'(perf(14))) begin
            n_fail++;
            $display("FAIL sat_preload: got %0d expected %0d", b_cnt, perf(14));
        end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(2, 0, 0, 1, 2, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0);
            step();
        end
        n_checks++;
        if (b_cnt !== 4'(perf(15))) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d expected %0d", b_cnt, perf(15));
        end
        n_checks++;
        if (a_cnt !== 32'(perf(15))) begin
            n_fail++;
            $display("FAIL sat_wide: got %0d expected %0d", a_cnt, perf(15));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        test_reset();
        test_lu1();
        test_no_hazard();
        test_lu3();
        test_taken();
        test_mem_wait();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
